rgmii_rx_decode: RTL and testbench
==================================

Name: rgmii_rx_decode

Overview:
- Consumes the registered rising/falling-edge samples of RGMII RXD[3:0] and RX_CTL produced by the generic input DDR stage.
- Produces a byte-wide GMII-style receive stream in both 1000 Mb/s (DDR) and 10/100 Mb/s (nibble, SDR) modes.
- Decodes RGMII in-band link status during inter-frame gaps.
- Sits between the RGMII PHY interface DDR capture and the Ethernet MAC receive path, in the RX clock domain.

Parameters:
- STATUS_STABLE, 2, consecutive identical inter-frame status samples required before the status outputs update (min 1).

Ports:
- clk  input  1  RX clock; same clock that drives the input DDR stage.
- rst  input  1  reset; asynchronous, active-high.
- rxd_q1  input  4  RXD sampled on the rising edge (low nibble in 1000 mode).
- rxd_q2  input  4  RXD sampled on the falling edge (high nibble in 1000 mode).
- ctl_q1  input  1  RX_CTL sampled on the rising edge (RX_DV).
- ctl_q2  input  1  RX_CTL sampled on the falling edge (RX_DV xor RX_ER).
- mii_select  input  1  1 = 10/100 nibble mode, 0 = 1000 DDR mode.
- gmii_rxd  output  8  received byte.
- gmii_rx_dv  output  1  data valid.
- gmii_rx_er  output  1  receive error.
- gmii_rx_ce  output  1  output strobe; the byte/dv/er outputs are meaningful only when this is 1.
- frame_start  output  1  one-cycle pulse with the first strobed byte of a frame.
- frame_end  output  1  one-cycle pulse on the cycle after the strobe of the last byte of a frame.
- link_up  output  1  decoded in-band link status.
- link_speed  output  2  decoded speed: 00 = 10, 01 = 100, 10 = 1000.
- full_duplex  output  1  decoded duplex.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched mode = 0; status counter = 0.
- Per-cycle decode: dv = ctl_q1; er = ctl_q1 ^ ctl_q2.
- Mode latch: mii_select is sampled only in IDLE. A change during a frame takes effect at the next IDLE.
- 1000 mode:
  - Every cycle: gmii_rxd = {rxd_q2, rxd_q1}, gmii_rx_dv = dv, gmii_rx_er = er, gmii_rx_ce = 1.
  - Registered, 1-cycle latency from the input samples.
- 10/100 mode: only rxd_q1 is used. FSM states are IDLE, LOW, HIGH.
  - IDLE -> LOW when dv = 1; store rxd_q1 as the low nibble and OR er into a sticky error flag.
  - LOW -> HIGH on the next cycle when dv = 1; emit {rxd_q1, low} with dv = 1, er = sticky | er, ce = 1; clear sticky.
  - HIGH -> LOW when dv = 1 (capture the next low nibble). HIGH -> IDLE when dv = 0.
  - Odd nibble count (LOW with dv = 0): emit {4'h0, low} with dv = 1, er = 1, ce = 1, then go to IDLE.
  - Latency: byte strobed 1 cycle after its high nibble is presented. ce = 1 at most every other cycle during a frame.
  - In IDLE with dv = 0: ce = 1 every cycle, dv = 0, er = er, rxd = {rxd_q1, rxd_q1}. This passes carrier-sense and false-carrier indications through.
- Framing:
  - frame_start is asserted coincident with the ce of the first byte that has dv = 1.
  - frame_end pulses for one cycle on the first cycle after the last dv = 1 byte was strobed.
  - A frame of N bytes in 1000 mode yields exactly N ce cycles with dv = 1.
- In-band status:
  - Sampled only when ctl_q1 = 0, ctl_q2 = 0, and the FSM is in IDLE.
  - Sample value is rxd_q1: bit0 = link, bits2:1 = speed, bit3 = duplex.
  - In 1000 mode the sample is also required to satisfy rxd_q1 == rxd_q2; otherwise it is discarded and the counter is cleared.
  - Outputs update after STATUS_STABLE consecutive identical samples. A differing sample restarts the count.
  - Speed code 11 is reserved: hold the previous link_speed, but still update link_up and full_duplex.
- Reset mid-frame: all outputs return to 0 asynchronously. A partial nibble is dropped; no frame_end is emitted.
- Carrier extension / error in 1000 mode (dv = 0, er = 1): passed through unchanged; status sampling is suppressed.

Test Plan:
- 1000 mode, 64-byte frame 0x00..0x3F with ctl_q1 = ctl_q2 = 1 -> 64 consecutive ce cycles carrying bytes 0x00..0x3F, dv = 1, er = 0. frame_start is on byte 0x00; frame_end is 1 cycle after 0x3F.
- 10/100 mode, nibbles 5,5,...,D,5 (preamble/SFD), then payload nibbles 4,3 -> bytes 0x55 repeated, then 0x5D, then 0x34. ce is asserted every 2nd cycle and dv = 1.
- 10/100 mode, frame with 3 nibbles A,B,C -> byte 0xBA (er = 0), then 0x0C with er = 1, then frame_end.
- Error mid-frame in 1000 mode: one cycle with ctl_q1 = 1, ctl_q2 = 0 on byte 5 -> that byte has er = 1, neighbouring bytes have er = 0, and dv stays 1 throughout.
- In-band status, 1000 mode, STATUS_STABLE = 2: idle with rxd_q1 = rxd_q2 = 4'b1101 for 2 cycles -> link_up = 1, link_speed = 10, full_duplex = 1. A single 4'b0000 sample does not change the outputs. A sample with rxd_q1 = 4'b1101, rxd_q2 = 4'b0101 is rejected.
- Toggle mii_select mid-frame -> decoding continues in the original mode until dv falls. Assert rst during a LOW state -> all outputs are 0 immediately, and no stray byte appears after reset is released.

Source files
------------

// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: turns registered RGMII DDR samples into a byte-wide GMII rx stream and decodes in-band link status.
module rgmii_rx_decode #(
  parameter int STATUS_STABLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       ctl_q1,
  input  logic       ctl_q2,
  input  logic       mii_select,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_rx_ce,
  output logic       frame_start,
  output logic       frame_end,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);
  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;
  localparam int CW = $clog2(STATUS_STABLE + 1);
  state_t state_q, state_d;
  logic mode_q, mode_d, sticky_q, sticky_d, infr_q, infr_d;
  logic [3:0] low_q, low_d, samp_q, samp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] rxd_d;
  logic dv, er, smp, dv_d, er_d, ce_d, fs_d, fe_d, link_d, dup_d;
  logic [1:0] spd_d;
  always_comb begin
    dv = ctl_q1;
    er = ctl_q1 ^ ctl_q2;
    mode_d = (state_q == IDLE) ? mii_select : mode_q;
    state_d = state_q;
    low_d = low_q;
    sticky_d = sticky_q;
    rxd_d = '0;
    dv_d = 1'b0;
    er_d = 1'b0;
    ce_d = 1'b0;
    if (!mode_d) begin
      // 1000 mode: HIGH simply marks "inside a frame" so the mode latch holds
      state_d = dv ? HIGH : IDLE;
      rxd_d = {rxd_q2, rxd_q1};
      dv_d = dv;
      er_d = er;
      ce_d = 1'b1;
      sticky_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, HIGH: begin
          if (dv) begin
            state_d = LOW;
            low_d = rxd_q1;
            sticky_d = sticky_q | er;
          end else if (state_q == IDLE) begin
            rxd_d = {rxd_q1, rxd_q1};
            er_d = er;
            ce_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        LOW: begin
          state_d = dv ? HIGH : IDLE;
          rxd_d = {dv ? rxd_q1 : 4'h0, low_q};
          dv_d = 1'b1;
          er_d = dv ? (sticky_q | er) : 1'b1;
          ce_d = 1'b1;
          sticky_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    fs_d = ce_d & dv_d & ~infr_q;
    fe_d = infr_q & ~(ce_d & dv_d) & (state_d == IDLE || state_q == IDLE);
    infr_d = (ce_d & dv_d) | (infr_q & ~fe_d);
    smp = ~ctl_q1 & ~ctl_q2 & (state_q == IDLE);
    cnt_d = cnt_q;
    samp_d = samp_q;
    link_d = link_up;
    spd_d = link_speed;
    dup_d = full_duplex;
    if (smp) begin
      if (!mode_d && rxd_q1 != rxd_q2) begin
        cnt_d = '0;
      end else begin
        samp_d = rxd_q1;
        cnt_d = (cnt_q != '0 && rxd_q1 == samp_q) ?
                ((cnt_q == CW'(STATUS_STABLE)) ? cnt_q : cnt_q + 1'b1) : CW'(1);
        if (cnt_d == CW'(STATUS_STABLE)) begin
          link_d = rxd_q1[0];
          dup_d = rxd_q1[3];
          spd_d = (rxd_q1[2:1] == 2'b11) ? link_speed : rxd_q1[2:1];
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q <= 1'b0;
      sticky_q <= 1'b0;
      infr_q <= 1'b0;
      low_q <= '0;
      samp_q <= '0;
      cnt_q <= '0;
      gmii_rxd <= '0;
      gmii_rx_dv <= 1'b0;
      gmii_rx_er <= 1'b0;
      gmii_rx_ce <= 1'b0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      link_up <= 1'b0;
      link_speed <= '0;
      full_duplex <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      sticky_q <= sticky_d;
      infr_q <= infr_d;
      low_q <= low_d;
      samp_q <= samp_d;
      cnt_q <= cnt_d;
      gmii_rxd <= rxd_d;
      gmii_rx_dv <= dv_d;
      gmii_rx_er <= er_d;
      gmii_rx_ce <= ce_d;
      frame_start <= fs_d;
      frame_end <= fe_d;
      link_up <= link_d;
      link_speed <= spd_d;
      full_duplex <= dup_d;
    end
  end
endmodule

// File: tb/tb_rgmii_rx_decode.sv
// tb_rgmii_rx_decode: directed RGMII rx vectors with a queue-based scoreboard checking strobed bytes and frame markers.
module tb_rgmii_rx_decode;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] rxd_q1 = '0, rxd_q2 = '0, idle_nib = 4'hD;
  logic ctl_q1 = 1'b0, ctl_q2 = 1'b0, mii_select = 1'b0;
  logic [7:0] gmii_rxd;
  logic gmii_rx_dv, gmii_rx_er, gmii_rx_ce, frame_start, frame_end, link_up, full_duplex;
  logic [1:0] link_speed;
  int checks = 0, failures = 0, cyc = 0, last = 0;
  typedef struct {bit fe; logic [7:0] d; bit er; bit fs; int gap;} exp_t;
  exp_t q[$];

  rgmii_rx_decode #(.STATUS_STABLE(2)) dut (
    .clk(clk), .rst(rst), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2), .ctl_q1(ctl_q1), .ctl_q2(ctl_q2),
    .mii_select(mii_select), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_rx_ce(gmii_rx_ce), .frame_start(frame_start), .frame_end(frame_end), .link_up(link_up),
    .link_speed(link_speed), .full_duplex(full_duplex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_b(input logic [7:0] d, input bit er, input bit fs, input int gap);
    exp_t e;
    e = '{1'b0, d, er, fs, gap};
    q.push_back(e);
  endtask

  task automatic push_fe();
    exp_t e;
    e = '{1'b1, 8'h00, 1'b0, 1'b0, 1};
    q.push_back(e);
  endtask

  task automatic tick(input logic [3:0] a, input logic [3:0] b, input logic c1, input logic c2);
    rxd_q1 = a;
    rxd_q2 = b;
    ctl_q1 = c1;
    ctl_q2 = c2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(idle_nib, idle_nib, 1'b0, 1'b0);
  endtask

  task automatic status(input string t, input logic l, input logic [1:0] s, input logic d);
    chk({t, " link_up"}, link_up, l);
    chk({t, " link_speed"}, link_speed, s);
    chk({t, " full_duplex"}, full_duplex, d);
  endtask

  task automatic all_zero(input string t);
    chk({t, " gmii_rxd"}, gmii_rxd, 0);
    chk({t, " gmii_rx_dv"}, gmii_rx_dv, 0);
    chk({t, " gmii_rx_er"}, gmii_rx_er, 0);
    chk({t, " gmii_rx_ce"}, gmii_rx_ce, 0);
    chk({t, " frame_start"}, frame_start, 0);
    chk({t, " frame_end"}, frame_end, 0);
    status(t, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic frame1000(input int n, input logic [7:0] base, input int err, input int tog);
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      d = base + 8'(i);
      if (i == tog) mii_select = ~mii_select;
      push_b(d, i == err, i == 0, (i == 0) ? 0 : 1);
      tick(d[3:0], d[7:4], 1'b1, i != err);
    end
    push_fe();
    idle(1);
  endtask

  task automatic mii_frame(input logic [63:0] nibs, input int n, input int tog);
    for (int i = 0; i < n; i++) begin
      logic [3:0] nb;
      nb = nibs[4*i +: 4];
      if (i == tog) mii_select = ~mii_select;
      if (i % 2 == 1) push_b({nb, nibs[4*i-4 +: 4]}, 1'b0, i == 1, (i == 1) ? 0 : 2);
      tick(nb, ~nb, 1'b1, 1'b1);
    end
    if (n % 2 == 1) begin
      push_b({4'h0, nibs[4*n-4 +: 4]}, 1'b1, n == 1, (n == 1) ? 0 : 2);
      idle(1);
    end
    push_fe();
    idle(1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (!rst) begin
      if (frame_end) begin
        chk("frame_end expected", q.size() > 0 && q[0].fe, 1);
        if (q.size() > 0 && q[0].fe) begin
          e = q.pop_front();
          chk("frame_end gap", cyc - last, 1);
        end
      end
      if (gmii_rx_ce && gmii_rx_dv) begin
        chk("byte expected", q.size() > 0 && !q[0].fe, 1);
        if (q.size() > 0 && !q[0].fe) begin
          e = q.pop_front();
          chk("gmii_rxd", gmii_rxd, e.d);
          chk("gmii_rx_er", gmii_rx_er, e.er);
          chk("frame_start", frame_start, e.fs);
          if (e.gap != 0) chk("byte gap", cyc - last, e.gap);
          last = cyc;
        end
      end else begin
        chk("frame_start without byte", frame_start, 0);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;
    tick(4'hD, 4'hD, 1'b0, 1'b0);
    status("one sample", 1'b0, 2'b00, 1'b0);
    chk("idle1000 ce", gmii_rx_ce, 1);
    chk("idle1000 dv", gmii_rx_dv, 0);
    chk("idle1000 rxd", gmii_rxd, 8'hDD);
    tick(4'hD, 4'hD, 1'b0, 1'b0);
    status("two samples", 1'b1, 2'b10, 1'b1);
    tick(4'h0, 4'h0, 1'b0, 1'b0);
    status("single 0000", 1'b1, 2'b10, 1'b1);
    tick(4'h3, 4'h3, 1'b0, 1'b0);
    tick(4'h3, 4'hB, 1'b0, 1'b0);
    tick(4'h3, 4'h3, 1'b0, 1'b0);
    status("mismatch clears", 1'b1, 2'b10, 1'b1);
    tick(4'h3, 4'h3, 1'b0, 1'b0);
    status("speed 100 half", 1'b1, 2'b01, 1'b0);
    tick(4'hD, 4'h5, 1'b0, 1'b0);
    tick(4'hD, 4'h5, 1'b0, 1'b0);
    status("q1!=q2 rejected", 1'b1, 2'b01, 1'b0);
    idle(2);
    tick(4'h7, 4'h7, 1'b0, 1'b0);
    tick(4'h7, 4'h7, 1'b0, 1'b0);
    status("reserved 0111", 1'b1, 2'b10, 1'b0);
    tick(4'hE, 4'hE, 1'b0, 1'b0);
    tick(4'hE, 4'hE, 1'b0, 1'b0);
    status("reserved 1110", 1'b0, 2'b10, 1'b1);
    idle(2);
    tick(4'h0, 4'h0, 1'b0, 1'b1);
    chk("carrier ext dv", gmii_rx_dv, 0);
    chk("carrier ext er", gmii_rx_er, 1);
    chk("carrier ext ce", gmii_rx_ce, 1);
    tick(4'h0, 4'h0, 1'b0, 1'b1);
    status("carrier ext no sample", 1'b1, 2'b10, 1'b1);
    idle(2);
    frame1000(64, 8'h00, -1, -1);
    idle(3);
    frame1000(8, 8'hA0, 5, -1);
    idle(3);
    mii_select = 1'b1;
    idle(2);
    tick(4'hD, 4'h2, 1'b0, 1'b0);
    chk("idle mii rxd", gmii_rxd, 8'hDD);
    chk("idle mii ce", gmii_rx_ce, 1);
    mii_frame(64'h0000_0034_5D55_5555, 10, -1);
    idle(2);
    mii_frame(64'h0000_0000_0000_0CBA, 3, -1);
    idle(2);
    mii_frame(64'h0000_0000_0000_4321, 4, 1);
    idle(2);
    frame1000(4, 8'h10, -1, 2);
    idle(2);
    mii_select = 1'b1;
    idle(2);
    push_b(8'h21, 1'b0, 1'b1, 0);
    tick(4'h1, 4'hE, 1'b1, 1'b1);
    tick(4'h2, 4'hD, 1'b1, 1'b1);
    tick(4'h3, 4'hC, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    all_zero("async reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    chk("queue drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
